// File: rtl/mem_arbiter.sv
// Shares one memory bus between the fetch port and the data port. One transaction runs at a time.
// The data port has priority, and a starvation guard lets fetch through when it has waited too long.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] starve_cnt;
  logic [7:0] timer;
  logic       busy;
  logic       timeout;
  logic       done;
  logic       if_forced;

  assign busy      = (state != IDLE);
  // An ack in the last watchdog cycle takes precedence over the abort.
  assign timeout   = (TIMEOUT != 0) && busy && !bus_ack && (timer == TIMER_LAST);
  assign done      = busy && (bus_ack || timeout);
  assign if_ready  = done && (state == BUSY_IF);
  assign dm_ready  = done && (state == BUSY_DM);
  assign bus_err   = timeout;
  assign if_rdata  = bus_rdata;
  assign dm_rdata  = bus_rdata;
  assign if_forced = if_req && (starve_cnt == STARVE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      starve_cnt <= '0;
      timer      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_req && !if_forced) begin
            state     <= BUSY_DM;
            bus_req   <= 1'b1;
            bus_we    <= dm_we;
            bus_addr  <= dm_addr;
            bus_wdata <= dm_wdata;
            timer     <= '0;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 8'd1;
          end else if (if_req) begin
            state      <= BUSY_IF;
            bus_req    <= 1'b1;
            bus_we     <= 1'b0;
            bus_addr   <= if_addr;
            bus_wdata  <= '0;
            timer      <= '0;
            starve_cnt <= '0;
          end
        end
        default: begin
          if (done) begin
            state   <= IDLE;
            bus_req <= 1'b0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified memory bus between the pipeline's instruction-fetch (IF) port and data-memory (MEM stage, load/store) port. Sequences one bus transaction at a time, gives the data port priority with a starvation guard for fetch, and pulses a per-port ready that the pipeline uses to release its stall. It sits between the IF/MEM stages and the external memory bus.

## Interface
- STARVE_LIMIT, 4: max consecutive DM grants while IF waits (1..255)
- TIMEOUT, 255: bus cycles without ack before abort (1..255); 0 disables the watchdog
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held high, if_addr stable, until if_ready
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word; valid only when if_ready=1
- if_ready  out  1  one-cycle completion pulse for IF
- dm_req  in  1  data request (MemRead|MemWrite); held with fields stable until dm_ready
- dm_we  in  1  1=store, 0=load
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data; valid only when dm_ready=1 and dm_we=0
- dm_ready  out  1  one-cycle completion pulse for DM
- bus_req  out  1  bus transaction active (registered)
- bus_we  out  1  bus write (registered)
- bus_addr  out  32  bus address (registered)
- bus_wdata  out  32  bus write data (registered)
- bus_rdata  in  32  read data, valid in the bus_ack cycle
- bus_ack  in  1  one-cycle completion from memory
- bus_err  out  1  one-cycle pulse with ready when a transaction aborted by timeout

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE: sample requests. Only dm_req -> BUSY_DM. Only if_req -> BUSY_IF. Both: BUSY_IF if starve_cnt == STARVE_LIMIT, else BUSY_DM. Neither: stay.
- On grant edge: register bus_req=1, bus_we (dm_we for DM, 0 for IF), bus_addr, bus_wdata (dm_wdata for DM, 0 for IF). Fields held constant through BUSY.
- starve_cnt (8 bit): on DM grant with if_req=1, increment (saturating at STARVE_LIMIT); on DM grant with if_req=0, or any IF grant, clear to 0.
- BUSY_x with bus_ack=1: x_ready=1 combinationally, x_rdata=bus_rdata (pass-through); next edge: bus_req=0, state IDLE. Non-granted port's ready stays 0; both rdata outputs always drive bus_rdata.
- Watchdog: timer cleared on grant, increments each BUSY cycle with bus_ack=0. If TIMEOUT!=0 and timer reaches TIMEOUT-1 with no ack: x_ready=1 and bus_err=1 that cycle, rdata undefined, next edge IDLE, bus_req=0.
- ack and timeout in the same cycle: ack wins, bus_err=0.
- bus_ack while IDLE: ignored, no ready.
- Requester rule: after its ready pulse, a requester may keep req high for a new transaction (new fields from next cycle); it is re-arbitrated in IDLE on the next cycle.
- Reset (asynchronous, any time incl. mid-transaction): state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, starve_cnt=0, timer=0; if_ready, dm_ready, bus_err=0. In-flight transaction dropped, no ready issued.

## Timing
- Request seen in IDLE at cycle 0 -> bus_req high cycle 1 -> ack earliest cycle 1 -> ready same cycle as ack. Minimum req-to-ready: 2 cycles (ready in cycle 1).
- Back-to-back: with ack in cycle N, next grant decided in cycle N+1 (IDLE), bus_req high cycle N+2. Bus idles one cycle minimum between transactions.
- ready/bus_err are combinational from bus_ack/timer; all bus_* outputs are registered.
- Timeout abort: ready+bus_err in cycle TIMEOUT after bus_req rises.

## Test plan
- IF only, if_addr=0x00400000, memory acks 3 cycles after bus_req rises, bus_rdata=0x2008000A -> bus_addr=0x00400000, bus_we=0, if_ready pulse with if_rdata=0x2008000A, dm_ready stays 0.
- if_req and dm_req (load 0x10010004) rise same cycle, ack latency 1 -> DM served first (dm_ready), IF served next transaction; exactly one ready per transaction.
- STARVE_LIMIT=2, if_req held, dm_req held continuously -> grant order DM, DM, IF, DM, DM, IF; starve_cnt returns to 0 after each IF grant.
- TIMEOUT=8, store to 0x10010000, bus_ack never asserted -> dm_ready and bus_err pulse 8 cycles after bus_req rise, bus_req low next cycle; repeat with ack in cycle 8 -> bus_err=0.
- rst_n low for 1 cycle mid BUSY_DM -> all outputs 0 immediately, later ack ignored, no ready; after release, held dm_req re-granted cleanly.
- Store 0xDEADBEEF to 0x10010008 then load same address, ack in the same cycle bus_req rises -> bus_we=1 then 0, one idle cycle between, dm_rdata=0xDEADBEEF on second ready.
